// File: rtl/uart_fifo_ctrl.sv
// rtl/uart_fifo_ctrl.sv - buffered COM port responder with RX/TX FIFOs and level interrupt
module uart_fifo_ctrl #(
  parameter int RX_DEPTH_LOG2 = 4,
  parameter int TX_DEPTH_LOG2 = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable_i,
  input  logic        readEnable_i,
  input  logic        mode_i,
  input  logic [31:0] dataSave_i,
  output logic [31:0] dataLoad_o,
  output logic        busy_o,
  output logic        int_o,
  input  logic        rxdReady_i,
  input  logic [7:0]  rxdData_i,
  input  logic        txdBusy_i,
  output logic        txdStart_o,
  output logic [7:0]  txdData_o
);
  localparam int RX_DEPTH = 1 << RX_DEPTH_LOG2;
  localparam int TX_DEPTH = 1 << TX_DEPTH_LOG2;
  localparam int RX_CW    = RX_DEPTH_LOG2 + 1;
  localparam int TX_CW    = TX_DEPTH_LOG2 + 1;
  localparam logic [RX_DEPTH_LOG2:0] RX_FULL_CNT = {1'b1, {RX_DEPTH_LOG2{1'b0}}};
  localparam logic [TX_DEPTH_LOG2:0] TX_FULL_CNT = {1'b1, {TX_DEPTH_LOG2{1'b0}}};

  typedef enum logic { IDLE, ACK } bus_state_e;
  typedef enum logic [1:0] { T_IDLE, T_START, T_WAIT } tx_state_e;

  bus_state_e bus_state_q, bus_state_d;
  tx_state_e  tx_state_q, tx_state_d;
  logic       wait_first_q, wait_first_d;

  logic [RX_DEPTH_LOG2-1:0] rx_wr_ptr_q, rx_wr_ptr_d, rx_rd_ptr_q, rx_rd_ptr_d;
  logic [RX_DEPTH_LOG2:0]   rx_cnt_q, rx_cnt_d;
  logic [TX_DEPTH_LOG2-1:0] tx_wr_ptr_q, tx_wr_ptr_d, tx_rd_ptr_q, tx_rd_ptr_d;
  logic [TX_DEPTH_LOG2:0]   tx_cnt_q, tx_cnt_d;

  logic [31:0] data_load_q, data_load_d;
  logic        int_q, int_d;
  logic        overrun_q, overrun_d;
  logic        rx_int_en_q, rx_int_en_d;
  logic [7:0]  txd_data_q, txd_data_d;

  logic [7:0] rx_mem [RX_DEPTH];
  logic [7:0] tx_mem [TX_DEPTH];

  logic rx_empty, rx_full, tx_empty, tx_full, tx_idle;
  logic wr_data, commit, rx_pop, rx_push, rx_drop, tx_push, tx_pop;
  logic [31:0] status;
  logic unused_bits;

  assign unused_bits = ^dataSave_i[31:8];

  assign rx_empty = (rx_cnt_q == '0);
  assign rx_full  = (rx_cnt_q == RX_FULL_CNT);
  assign tx_empty = (tx_cnt_q == '0);
  assign tx_full  = (tx_cnt_q == TX_FULL_CNT);
  assign tx_idle  = tx_empty && (tx_state_q == T_IDLE) && !txdBusy_i;
  assign tx_pop   = (tx_state_q == T_START);

  // A write into a full TX FIFO may still commit when the drain frees a slot this cycle.
  assign wr_data = enable_i && !readEnable_i && !mode_i;
  assign commit  = (bus_state_q == IDLE) && enable_i && !(wr_data && tx_full && !tx_pop);
  assign rx_pop  = commit && readEnable_i && !mode_i && !rx_empty;
  assign rx_push = rxdReady_i && (!rx_full || rx_pop);
  assign rx_drop = rxdReady_i && rx_full && !rx_pop;
  assign tx_push = commit && wr_data;
  assign status  = {27'h0, rx_int_en_q, tx_idle, overrun_q, !rx_empty, !tx_full};

  assign busy_o     = rst_n && (bus_state_q == IDLE) && enable_i;
  assign dataLoad_o = data_load_q;
  assign int_o      = int_q;
  assign txdStart_o = (tx_state_q == T_START);
  assign txdData_o  = txd_data_q;

  always_comb begin
    bus_state_d  = bus_state_q;
    tx_state_d   = tx_state_q;
    wait_first_d = wait_first_q;
    data_load_d  = data_load_q;
    overrun_d    = overrun_q;
    rx_int_en_d  = rx_int_en_q;
    txd_data_d   = txd_data_q;
    int_d        = rx_int_en_q && !rx_empty;

    rx_wr_ptr_d = rx_wr_ptr_q + (rx_push ? RX_DEPTH_LOG2'(1) : '0);
    rx_rd_ptr_d = rx_rd_ptr_q + (rx_pop  ? RX_DEPTH_LOG2'(1) : '0);
    rx_cnt_d    = rx_cnt_q + (rx_push ? RX_CW'(1) : '0) - (rx_pop ? RX_CW'(1) : '0);
    tx_wr_ptr_d = tx_wr_ptr_q + (tx_push ? TX_DEPTH_LOG2'(1) : '0);
    tx_rd_ptr_d = tx_rd_ptr_q + (tx_pop  ? TX_DEPTH_LOG2'(1) : '0);
    tx_cnt_d    = tx_cnt_q + (tx_push ? TX_CW'(1) : '0) - (tx_pop ? TX_CW'(1) : '0);

    case (bus_state_q)
      IDLE: if (commit) bus_state_d = ACK;
      default: bus_state_d = IDLE;
    endcase

    if (commit) begin
      if (readEnable_i) begin
        if (mode_i) begin
          data_load_d = status;
          overrun_d   = 1'b0;
        end else begin
          data_load_d = rx_empty ? 32'h0 : {24'h0, rx_mem[rx_rd_ptr_q]};
        end
      end else begin
        data_load_d = 32'h0;
        if (mode_i) rx_int_en_d = dataSave_i[4];
      end
    end
    // A byte lost in the same cycle as a status read must not be hidden by the clear.
    if (rx_drop) overrun_d = 1'b1;

    case (tx_state_q)
      T_IDLE: begin
        if (!tx_empty && !txdBusy_i) begin
          tx_state_d = T_START;
          txd_data_d = tx_mem[tx_rd_ptr_q];
        end
      end
      T_START: begin
        tx_state_d   = T_WAIT;
        wait_first_d = 1'b1;
      end
      default: begin
        if (wait_first_q)    wait_first_d = 1'b0;
        else if (!txdBusy_i) tx_state_d   = T_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rx_push) rx_mem[rx_wr_ptr_q] <= rxdData_i;
    if (tx_push) tx_mem[tx_wr_ptr_q] <= dataSave_i[7:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus_state_q  <= IDLE;
      tx_state_q   <= T_IDLE;
      wait_first_q <= 1'b0;
      rx_wr_ptr_q  <= '0;
      rx_rd_ptr_q  <= '0;
      rx_cnt_q     <= '0;
      tx_wr_ptr_q  <= '0;
      tx_rd_ptr_q  <= '0;
      tx_cnt_q     <= '0;
      data_load_q  <= '0;
      int_q        <= 1'b0;
      overrun_q    <= 1'b0;
      rx_int_en_q  <= 1'b0;
      txd_data_q   <= '0;
    end else begin
      bus_state_q  <= bus_state_d;
      tx_state_q   <= tx_state_d;
      wait_first_q <= wait_first_d;
      rx_wr_ptr_q  <= rx_wr_ptr_d;
      rx_rd_ptr_q  <= rx_rd_ptr_d;
      rx_cnt_q     <= rx_cnt_d;
      tx_wr_ptr_q  <= tx_wr_ptr_d;
      tx_rd_ptr_q  <= tx_rd_ptr_d;
      tx_cnt_q     <= tx_cnt_d;
      data_load_q  <= data_load_d;
      int_q        <= int_d;
      overrun_q    <= overrun_d;
      rx_int_en_q  <= rx_int_en_d;
      txd_data_q   <= txd_data_d;
    end
  end
endmodule
